mcp4725_arbiter: RTL and testbench

//  Shares one mcp4725 DAC interface between N_REQ requesters. Round-robin arbitration.

---
 rtl/mcp4725_ctrl_pkg.sv | 20 ++
 rtl/mcp4725_arbiter_rr_arbiter.sv | 26 ++
 rtl/mcp4725_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mcp4725_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp4725_ctrl_pkg.sv
// Shared encodings for the mcp4725 request arbiter: request opcodes,
// sequencer states and the response error flag.
package mcp4725_ctrl_pkg;

  localparam logic [1:0] OP_UPDATE  = 2'b00;
  localparam logic [1:0] OP_WRMEM   = 2'b01;
  localparam logic [1:0] OP_RDMEM   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic RSP_ERR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_RESP       = 3'd4
  } state_e;

endpackage

// File: rtl/mcp4725_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand_s;

  // scan from the farthest slot back towards ptr so the nearest request wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = {IW{1'b0}};
    cand_s    = {IW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      cand_s    = IW'((int'(ptr) + k) % N);
      gnt_valid = gnt_valid | req[cand_s];
      gnt_idx   = req[cand_s] ? cand_s : gnt_idx;
    end
  end

endmodule

// File: rtl/mcp4725_arbiter.sv
// Shares one mcp4725 DAC controller between N_REQ requesters: round-robin grant,
// pin sequencing, bus-release completion tracking with timeout, per-requester response.
module mcp4725_arbiter
  import mcp4725_ctrl_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  localparam int IW            = $clog2(N_REQ),
  localparam int CW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [2*N_REQ-1:0]  req_op,
  input  logic [12*N_REQ-1:0] req_data,
  input  logic [2*N_REQ-1:0]  req_mode,
  output logic [N_REQ-1:0]    rsp_done,
  output logic                rsp_err,
  output logic [11:0]         rsp_data,
  output logic [1:0]          rsp_mode,
  output logic [IW-1:0]       grant_id,
  output logic                busy,
  output logic [11:0]         dac_data,
  output logic [1:0]          dac_mode,
  output logic                dac_enable,
  output logic                dac_write_mem,
  output logic                dac_read_mem,
  input  logic [11:0]         dac_data_reg,
  input  logic [1:0]          dac_mode_reg,
  input  logic                dac_bus_idle
);

  state_e            state_r, state_s;
  logic [IW-1:0]     ptr_r, grant_id_r;
  logic [1:0]        op_r;
  logic              err_r;
  logic [CW-1:0]     cnt_r;
  logic [N_REQ-1:0]  rsp_done_r;
  logic              rsp_err_r, busy_r;
  logic [11:0]       rsp_data_r, dac_data_r;
  logic [1:0]        rsp_mode_r, dac_mode_r;
  logic              dac_enable_r, dac_write_mem_r, dac_read_mem_r;

  logic              gnt_valid_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [1:0]        sel_op_s, sel_mode_s;
  logic [11:0]       sel_data_s;
  logic              fast_s, tmo_s;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_r),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // payload of the requester the arbiter is currently pointing at
  always_comb begin
    sel_op_s   = OP_UPDATE;
    sel_data_s = 12'd0;
    sel_mode_s = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_op_s   = (gnt_idx_s == IW'(i)) ? req_op[2*i +: 2]    : sel_op_s;
      sel_data_s = (gnt_idx_s == IW'(i)) ? req_data[12*i +: 12] : sel_data_s;
      sel_mode_s = (gnt_idx_s == IW'(i)) ? req_mode[2*i +: 2]  : sel_mode_s;
    end
  end

  // an update that would not change the DAC needs no bus traffic
  assign fast_s = (op_r == OP_ILLEGAL) ||
                  ((op_r == OP_UPDATE) && (dac_data_r == dac_data_reg) && (dac_mode_r == dac_mode_reg));
  assign tmo_s  = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) state_s = ST_ISSUE;
        else             state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (fast_s) state_s = ST_RESP;
        else        state_s = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!dac_bus_idle) state_s = ST_WAIT_DONE;
        else if (tmo_s)    state_s = ST_RESP;
        else               state_s = ST_WAIT_START;
      end
      ST_WAIT_DONE: begin
        if (dac_bus_idle || tmo_s) state_s = ST_RESP;
        else                       state_s = ST_WAIT_DONE;
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // grant capture, DAC pin sequencing, timeout counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r           <= {IW{1'b0}};
      grant_id_r      <= {IW{1'b0}};
      op_r            <= OP_UPDATE;
      err_r           <= 1'b0;
      cnt_r           <= {CW{1'b0}};
      rsp_done_r      <= {N_REQ{1'b0}};
      rsp_err_r       <= 1'b0;
      rsp_data_r      <= 12'd0;
      rsp_mode_r      <= 2'd0;
      busy_r          <= 1'b0;
      dac_data_r      <= 12'd0;
      dac_mode_r      <= 2'd0;
      dac_enable_r    <= 1'b0;
      dac_write_mem_r <= 1'b0;
      dac_read_mem_r  <= 1'b0;
    end else begin
      rsp_done_r      <= {N_REQ{1'b0}};
      rsp_err_r       <= 1'b0;
      dac_write_mem_r <= 1'b0;
      dac_read_mem_r  <= 1'b0;
      busy_r          <= (state_s != ST_IDLE) || (state_r == ST_RESP);
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            grant_id_r <= gnt_idx_s;
            op_r       <= sel_op_s;
            dac_data_r <= sel_data_s;
            dac_mode_r <= sel_mode_s;
            err_r      <= 1'b0;
            ptr_r      <= (gnt_idx_s == IW'(N_REQ - 1)) ? {IW{1'b0}} : gnt_idx_s + IW'(1);
          end
        end
        ST_ISSUE: begin
          cnt_r <= {CW{1'b0}};
          if (fast_s) begin
            err_r <= (op_r == OP_ILLEGAL) ? RSP_ERR : 1'b0;
          end else begin
            case (op_r)
              OP_UPDATE: dac_enable_r    <= 1'b1;
              OP_WRMEM:  dac_write_mem_r <= 1'b1;
              OP_RDMEM:  dac_read_mem_r  <= 1'b1;
              default:   dac_enable_r    <= 1'b0;
            endcase
          end
        end
        ST_WAIT_START: begin
          if (!dac_bus_idle) begin
            dac_enable_r <= 1'b0;
            cnt_r        <= {CW{1'b0}};
          end else if (tmo_s) begin
            dac_enable_r <= 1'b0;
            err_r        <= RSP_ERR;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (dac_bus_idle) begin
            dac_enable_r <= 1'b0;
          end else if (tmo_s) begin
            dac_enable_r <= 1'b0;
            err_r        <= RSP_ERR;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_RESP: begin
          rsp_done_r <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_r;
          rsp_err_r  <= err_r;
          rsp_data_r <= dac_data_reg;
          rsp_mode_r <= dac_mode_reg;
        end
        default: dac_enable_r <= 1'b0;
      endcase
    end
  end

  assign rsp_done      = rsp_done_r;
  assign rsp_err       = rsp_err_r;
  assign rsp_data      = rsp_data_r;
  assign rsp_mode      = rsp_mode_r;
  assign grant_id      = grant_id_r;
  assign busy          = busy_r;
  assign dac_data      = dac_data_r;
  assign dac_mode      = dac_mode_r;
  assign dac_enable    = dac_enable_r;
  assign dac_write_mem = dac_write_mem_r;
  assign dac_read_mem  = dac_read_mem_r;

endmodule

// File: tb/tb_mcp4725_arbiter.sv
// Self-checking bench for mcp4725_arbiter: behavioural DAC model on the pins,
// abstract reference (register/EEPROM contents, round-robin pointer) for expected responses.
module tb_mcp4725_arbiter;

  localparam int N   = 4;
  localparam int TMO = 50;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [2*N-1:0]  req_op = '0;
  logic [12*N-1:0] req_data = '0;
  logic [2*N-1:0]  req_mode = '0;
  logic [N-1:0]    rsp_done;
  logic            rsp_err;
  logic [11:0]     rsp_data;
  logic [1:0]      rsp_mode;
  logic [1:0]      grant_id;
  logic            busy;
  logic [11:0]     dac_data;
  logic [1:0]      dac_mode;
  logic            dac_enable, dac_write_mem, dac_read_mem;
  logic [11:0]     dac_data_reg;
  logic [1:0]      dac_mode_reg;
  logic            dac_bus_idle;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mcp4725_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_mode(req_mode),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_data(rsp_data), .rsp_mode(rsp_mode),
    .grant_id(grant_id), .busy(busy),
    .dac_data(dac_data), .dac_mode(dac_mode), .dac_enable(dac_enable),
    .dac_write_mem(dac_write_mem), .dac_read_mem(dac_read_mem),
    .dac_data_reg(dac_data_reg), .dac_mode_reg(dac_mode_reg), .dac_bus_idle(dac_bus_idle)
  );

  // behavioural mcp4725: bus busy 5 cycles after a trigger, released 40 cycles later
  logic        model_on = 1'b1;
  logic [11:0] m_data = 12'd0, m_ee_data = 12'd0, m_lat_d = 12'd0;
  logic [1:0]  m_mode = 2'd0, m_ee_mode = 2'd0, m_lat_m = 2'd0, m_op = 2'd0;
  logic        m_idle = 1'b1, m_active = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_active <= 1'b0; m_cnt <= 0;
    end else if (!m_active) begin
      if (model_on && (dac_enable || dac_write_mem || dac_read_mem)) begin
        m_active <= 1'b1; m_cnt <= 0;
        m_op     <= dac_write_mem ? 2'd1 : (dac_read_mem ? 2'd2 : 2'd0);
        m_lat_d  <= dac_data; m_lat_m <= dac_mode;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 4) m_idle <= 1'b0;
      if (m_cnt == 44) begin
        m_idle <= 1'b1; m_active <= 1'b0;
        if (m_op == 2'd2) begin
          m_data <= m_ee_data; m_mode <= m_ee_mode;
        end else begin
          m_data <= m_lat_d; m_mode <= m_lat_m;
          if (m_op == 2'd1) begin m_ee_data <= m_lat_d; m_ee_mode <= m_lat_m; end
        end
      end
    end
  end

  assign dac_bus_idle = m_idle;
  assign dac_data_reg = m_data;
  assign dac_mode_reg = m_mode;

  int en_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  always @(negedge clk) begin
    if (dac_enable)    en_cnt <= en_cnt + 1;
    if (dac_write_mem) wr_cnt <= wr_cnt + 1;
    if (dac_read_mem)  rd_cnt <= rd_cnt + 1;
  end

  // reference: what the DAC should hold, and where round-robin stands
  logic [11:0] r_data = 12'd0, r_ee_data = 12'd0;
  logic [1:0]  r_mode = 2'd0, r_ee_mode = 2'd0;
  int          r_ptr = 0;
  int          glog[$];

  task automatic apply_req(input int i, input logic [1:0] op, input logic [11:0] d, input logic [1:0] m);
    req_op[2*i +: 2]    = op;
    req_data[12*i +: 12] = d;
    req_mode[2*i +: 2]  = m;
    req_valid[i]        = 1'b1;
  endtask

  task automatic ref_resp(input int i, output logic e, output logic [11:0] d, output logic [1:0] m);
    logic [1:0]  op;
    logic [11:0] pd;
    logic [1:0]  pm;
    op = req_op[2*i +: 2]; pd = req_data[12*i +: 12]; pm = req_mode[2*i +: 2];
    e = 1'b0;
    case (op)
      2'b00: begin r_data = pd; r_mode = pm; end
      2'b01: begin r_data = pd; r_mode = pm; r_ee_data = pd; r_ee_mode = pm; end
      2'b10: begin r_data = r_ee_data; r_mode = r_ee_mode; end
      default: e = 1'b1;
    endcase
    d = r_data; m = r_mode;
  endtask

  task automatic collect(input int n, input int reraise);
    int left;
    left = reraise;
    for (int k = 0; k < n; k++) begin
      int waited, exp_i, act_i;
      logic e_err;
      logic [11:0] e_d;
      logic [1:0] e_m;
      logic [N-1:0] e_done;
      waited = 0; exp_i = 0; act_i = -1;
      do begin @(negedge clk); waited++; end while (rsp_done == '0 && waited < 2000);
      n_vec++;
      if (rsp_done == '0) begin
        $display("FAIL done_wait: got no rsp_done, required one within 2000 cycles");
        n_err++;
        return;
      end
      for (int j = N - 1; j >= 0; j--) if (req_valid[(r_ptr + j) % N]) exp_i = (r_ptr + j) % N;
      for (int j = 0; j < N; j++) if (rsp_done[j]) act_i = j;
      glog.push_back(act_i);
      ref_resp(exp_i, e_err, e_d, e_m);
      e_done = '0; e_done[exp_i] = 1'b1;
      n_vec++; if (rsp_done !== e_done) begin $display("FAIL rsp_done: got %b required %b", rsp_done, e_done); n_err++; end
      n_vec++; if (grant_id !== 2'(exp_i)) begin $display("FAIL grant_id: got %0d required %0d", grant_id, exp_i); n_err++; end
      n_vec++; if (rsp_err !== e_err) begin $display("FAIL rsp_err: got %b required %b", rsp_err, e_err); n_err++; end
      n_vec++; if (rsp_data !== e_d) begin $display("FAIL rsp_data: got %h required %h", rsp_data, e_d); n_err++; end
      n_vec++; if (rsp_mode !== e_m) begin $display("FAIL rsp_mode: got %0d required %0d", rsp_mode, e_m); n_err++; end
      n_vec++; if (busy !== 1'b1) begin $display("FAIL busy_at_done: got %b required 1", busy); n_err++; end
      r_ptr = (exp_i + 1) % N;
      if (left > 0 && act_i == 0) begin
        left--;
        req_op[1:0] = 2'b11;
      end else if (act_i >= 0) begin
        req_valid[act_i] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({busy, rsp_done, rsp_err, dac_enable, dac_write_mem, dac_read_mem} !== '0) begin
      $display("FAIL reset_ctrl: got %b required all zero", {busy, rsp_done, rsp_err, dac_enable, dac_write_mem, dac_read_mem}); n_err++; end
    n_vec++; if ({dac_data, dac_mode, grant_id, rsp_data, rsp_mode} !== '0) begin
      $display("FAIL reset_data: got %h required zero", {dac_data, dac_mode, grant_id, rsp_data, rsp_mode}); n_err++; end
    @(negedge clk);
    rst_n = 1'b1;
    r_ptr = 0;
  endtask

  task automatic test_update();
    int w;
    @(negedge clk);
    apply_req(0, 2'b00, 12'h7FF, 2'd0);
    w = 0;
    do begin @(posedge clk); #1; w++; end while (dac_bus_idle !== 1'b0 && w < 200);
    n_vec++; if (dac_enable !== 1'b1) begin $display("FAIL enable_until_start: got %b required 1", dac_enable); n_err++; end
    n_vec++; if (dac_data !== 12'h7FF) begin $display("FAIL dac_data_drive: got %h required 7ff", dac_data); n_err++; end
    @(posedge clk); #1;
    n_vec++; if (dac_enable !== 1'b0) begin $display("FAIL enable_drop: got %b required 0", dac_enable); n_err++; end
    collect(1, 0);
  endtask

  task automatic test_fast_path();
    int cyc, e0, w0, r0;
    logic e; logic [11:0] d; logic [1:0] m;
    @(negedge clk);
    apply_req(1, 2'b00, 12'h123, 2'd1);
    collect(1, 0);
    e0 = en_cnt; w0 = wr_cnt; r0 = rd_cnt;
    apply_req(1, 2'b00, 12'h123, 2'd1);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (rsp_done == '0 && cyc < 20);
    n_vec++; if (cyc != 3) begin $display("FAIL fast_latency: got %0d required 3", cyc); n_err++; end
    n_vec++; if (rsp_done !== 4'b0010) begin $display("FAIL fast_done: got %b required 0010", rsp_done); n_err++; end
    ref_resp(1, e, d, m);
    n_vec++; if ({rsp_err, rsp_data, rsp_mode} !== {e, d, m}) begin
      $display("FAIL fast_rsp: got %h required %h", {rsp_err, rsp_data, rsp_mode}, {e, d, m}); n_err++; end
    r_ptr = 2;
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_vec++; if ({en_cnt - e0, wr_cnt - w0, rd_cnt - r0} !== {32'd0, 32'd0, 32'd0}) begin
      $display("FAIL fast_no_pins: got %0d/%0d/%0d pin cycles required 0", en_cnt - e0, wr_cnt - w0, rd_cnt - r0); n_err++; end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    apply_req(3, 2'b11, 12'h000, 2'd0);
    collect(1, 0);
    glog.delete();
    apply_req(0, 2'b11, 12'($urandom), 2'($urandom));
    apply_req(1, 2'b00, 12'($urandom), 2'($urandom));
    apply_req(2, 2'b01, 12'($urandom), 2'($urandom));
    apply_req(3, 2'b10, 12'($urandom), 2'($urandom));
    collect(5, 1);
    n_vec++; if (glog.size() != 5) begin $display("FAIL rr_count: got %0d required 5", glog.size()); n_err++; end
    for (int i = 0; i < 5 && i < glog.size(); i++) begin
      n_vec++; if (glog[i] != exp_order[i]) begin $display("FAIL rr_order[%0d]: got %0d required %0d", i, glog[i], exp_order[i]); n_err++; end
    end
  endtask

  task automatic test_read_mem();
    int r0, w0;
    apply_req(3, 2'b01, 12'hABC, 2'd2);
    collect(1, 0);
    apply_req(1, 2'b00, 12'h055, 2'd1);
    collect(1, 0);
    r0 = rd_cnt; w0 = wr_cnt;
    apply_req(2, 2'b10, 12'h000, 2'd0);
    collect(1, 0);
    n_vec++; if (rd_cnt - r0 != 1) begin $display("FAIL read_pulse: got %0d cycles required 1", rd_cnt - r0); n_err++; end
    n_vec++; if (wr_cnt - w0 != 0) begin $display("FAIL read_no_write: got %0d cycles required 0", wr_cnt - w0); n_err++; end
    n_vec++; if ({rsp_data, rsp_mode} !== {12'hABC, 2'd2}) begin
      $display("FAIL read_data: got %h/%0d required abc/2", rsp_data, rsp_mode); n_err++; end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int mask, cnt;
      mask = $urandom_range(1, 15); cnt = 0;
      for (int i = 0; i < N; i++) if (mask[i]) begin
        apply_req(i, 2'($urandom_range(0, 3)), 12'($urandom), 2'($urandom));
        cnt++;
      end
      collect(cnt, 0);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    @(negedge clk);
    model_on = 1'b0;
    apply_req(0, 2'b00, ~r_data, r_mode);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (rsp_done == '0 && cyc < 200);
    n_vec++; if (cyc != TMO + 3) begin $display("FAIL tmo_latency: got %0d required %0d", cyc, TMO + 3); n_err++; end
    n_vec++; if ({rsp_done, rsp_err} !== {4'b0001, 1'b1}) begin
      $display("FAIL tmo_rsp: got done=%b err=%b required 0001/1", rsp_done, rsp_err); n_err++; end
    n_vec++; if ({rsp_data, rsp_mode} !== {r_data, r_mode}) begin
      $display("FAIL tmo_data: got %h/%0d required %h/%0d", rsp_data, rsp_mode, r_data, r_mode); n_err++; end
    r_ptr = 1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({busy, dac_enable} !== 2'b00) begin $display("FAIL tmo_release: got busy=%b en=%b required 0/0", busy, dac_enable); n_err++; end
    model_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge clk);
    apply_req(2, 2'b01, 12'h5A5, 2'd3);
    w = 0;
    do begin @(posedge clk); #1; w++; end while (dac_bus_idle !== 1'b0 && w < 200);
    repeat (3) @(posedge clk);
    apply_req(3, 2'b00, 12'($urandom), 2'($urandom));
    apply_req(1, 2'b11, 12'h000, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, rsp_done, rsp_err, dac_enable, dac_write_mem, dac_read_mem, grant_id} !== '0) begin
      $display("FAIL midrst_ctrl: got %b required all zero", {busy, rsp_done, rsp_err, dac_enable, dac_write_mem, dac_read_mem, grant_id}); n_err++; end
    n_vec++; if ({dac_data, dac_mode} !== '0) begin $display("FAIL midrst_dac: got %h required zero", {dac_data, dac_mode}); n_err++; end
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r_ptr = 0;
    glog.delete();
    collect(2, 0);
    n_vec++; if (glog.size() < 1 || glog[0] != 1) begin $display("FAIL midrst_first_grant: got %0d required 1", (glog.size() > 0) ? glog[0] : -1); n_err++; end
  endtask

  initial begin
    test_reset();
    test_update();
    test_fast_path();
    test_round_robin();
    test_read_mem();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
